// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------------------
// serial_tx -- parallel-in, serial-out transmitter
//
// Accepts a WIDTH-bit word over a valid/ready handshake. It then shifts the word out
// one bit per enabled clock edge on serOut, for a downstream capture register that
// samples serOut while frame is high. A one-cycle done pulse follows the last bit.
//
// Parameters
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
// Ports
//   clk        rising-edge clock
//   resetN     asynchronous active-low reset
//   dataIn     word to send, sampled only on the accept edge
//   loadValid  producer offers a word on dataIn
//   loadReady  combinational, high while idle (a word can be accepted)
//   shiftEn    advance enable; low freezes an active frame
//   serOut     registered serial data, idles at 1
//   frame      registered, high while serOut carries a data bit
//   done       registered, one-cycle pulse after the last bit
// ---------------------------------------------------------------------------------------
module serial_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             loadValid,
    output logic             loadReady,
    input  logic             shiftEn,
    output logic             serOut,
    output logic             frame,
    output logic             done
);

    if (WIDTH < 2) begin : g_width_check
        $error("serial_tx: WIDTH must be at least 2");
    end

    // bitCnt runs 0..WIDTH inclusive, so it needs one extra code above WIDTH-1.
    localparam int unsigned   CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               ser_q, ser_d;
    logic               frame_q, frame_d;
    logic               done_q, done_d;

    logic               accept;
    logic               bit_step;
    logic               frame_end;
    logic               next_bit;
    logic [WIDTH-1:0]   shift_next;

    // -----------------------------------------------------------------------------------
    // Handshake and shift decode
    // -----------------------------------------------------------------------------------
    always_comb begin
        accept    = (state_q == StIdle) && loadValid;
        bit_step  = (state_q == StShift) && shiftEn && (cnt_q != CntLast);
        frame_end = (state_q == StShift) && shiftEn && (cnt_q == CntLast);
    end

    // The outgoing bit always sits at the leading end of the shift register, so the
    // register is shifted towards that end after each bit rather than indexed by bitCnt.
    always_comb begin
        if (MSB_FIRST) begin
            next_bit   = shift_q[WIDTH-1];
            shift_next = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            next_bit   = shift_q[0];
            shift_next = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    // -----------------------------------------------------------------------------------
    // State register (also holds the datapath registers)
    // -----------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b1;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (frame_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values. With shiftEn low in StShift none of the branches fire, so
    // every register holds and the frame is frozen. done defaults low, which keeps it a
    // single-cycle pulse.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        frame_d = frame_q;
        done_d  = 1'b0;

        if (accept) begin
            // serOut and frame are left as they are: the first bit appears one edge later.
            shift_d = dataIn;
            cnt_d   = '0;
        end else if (bit_step) begin
            shift_d = shift_next;
            ser_d   = next_bit;
            frame_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
        end else if (frame_end) begin
            ser_d   = 1'b1;
            frame_d = 1'b0;
            done_d  = 1'b1;
        end
    end

    // -----------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------
    always_comb begin
        loadReady = (state_q == StIdle);
        serOut    = ser_q;
        frame     = frame_q;
        done      = done_q;
    end

    // -----------------------------------------------------------------------------------
    // Internal consistency properties
    // -----------------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_cnt_range : assert property (@(posedge clk) disable iff (!resetN)
        cnt_q <= CntLast);
    a_frame_in_shift : assert property (@(posedge clk) disable iff (!resetN)
        frame_q |-> (state_q == StShift));
    a_done_idle : assert property (@(posedge clk) disable iff (!resetN)
        done_q |-> (!frame_q && state_q == StIdle));
    a_idle_level : assert property (@(posedge clk) disable iff (!resetN)
        !frame_q |-> ser_q);
`endif

endmodule

// File: tb/tb_serial_tx.sv
// ---------------------------------------------------------------------------------------
// tb_serial_tx -- bench for serial_tx
//
// Two instances share clock, reset, dataIn and shiftEn: lane 0 is MSB-first and lane 1
// is LSB-first. Only one lane transmits at a time. Each accepted word pushes its serial
// bit sequence onto a queue, and a monitor pops it as bits appear on the active lane.
// ---------------------------------------------------------------------------------------
module tb_serial_tx;

    localparam int unsigned W = 8;

    logic         clk;
    logic         resetN;
    logic [W-1:0] dataIn;
    logic         shiftEn;
    logic         loadValid_a, loadReady_a, serOut_a, frame_a, done_a;
    logic         loadValid_b, loadReady_b, serOut_b, frame_b, done_b;

    serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk       (clk),
        .resetN    (resetN),
        .dataIn    (dataIn),
        .loadValid (loadValid_a),
        .loadReady (loadReady_a),
        .shiftEn   (shiftEn),
        .serOut    (serOut_a),
        .frame     (frame_a),
        .done      (done_a)
    );

    serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .resetN    (resetN),
        .dataIn    (dataIn),
        .loadValid (loadValid_b),
        .loadReady (loadReady_b),
        .shiftEn   (shiftEn),
        .serOut    (serOut_b),
        .frame     (frame_b),
        .done      (done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Scoreboard and monitor state
    bit exp_q[$];
    int lane;
    bit last_bit;
    bit prev_fr;
    bit prev_dn;
    int frame_len;
    int done_cnt;

    // seq holds the expected serial order, first bit transmitted in seq[7].
    typedef struct {
        logic [7:0] data;
        int         lane;
        logic [7:0] seq;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the active lane against the scoreboard after each edge.
    task automatic mon(input bit se);
        logic fr, so, dn, ofr, odn;
        fr  = (lane == 0) ? frame_a  : frame_b;
        so  = (lane == 0) ? serOut_a : serOut_b;
        dn  = (lane == 0) ? done_a   : done_b;
        ofr = (lane == 0) ? frame_b  : frame_a;
        odn = (lane == 0) ? done_b   : done_a;
        chk("other_lane_frame", ofr, 0);
        chk("other_lane_done", odn, 0);
        if (fr) begin
            frame_len++;
            if (se) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_bit: got serOut=%b expected no bit at %0t", so, $time);
                end else begin
                    last_bit = exp_q.pop_front();
                    chk("ser_bit", so, last_bit);
                end
            end else begin
                chk("ser_hold", so, last_bit);
            end
        end else begin
            chk("ser_idle", so, 1);
        end
        if (dn) begin
            done_cnt++;
            chk("done_after_frame", prev_fr, 1);
            chk("done_frame_low", fr, 0);
            chk("done_bits_left", exp_q.size(), 0);
            chk("done_pulse", prev_dn, 0);
        end
        prev_fr = fr;
        prev_dn = dn;
    endtask

    task automatic tick();
        bit se;
        se = shiftEn;
        @(posedge clk);
        #1;
        mon(se);
    endtask

    // Offer a word on one lane; keep leaves loadValid asserted afterwards.
    task automatic send_word(input logic [7:0] data, input logic [7:0] seq, input int ln,
                             input bit keep);
        lane   = ln;
        dataIn = data;
        if (ln == 0) begin
            chk("ready_a", loadReady_a, 1);
            loadValid_a = 1'b1;
        end else begin
            chk("ready_b", loadReady_b, 1);
            loadValid_b = 1'b1;
        end
        tick();
        if (!keep) begin
            loadValid_a = 1'b0;
            loadValid_b = 1'b0;
        end
        for (int i = 7; i >= 0; i--) exp_q.push_back(seq[i]);
        frame_len = 0;
        done_cnt  = 0;
    endtask

    // Tick until done is seen (bounded), then check frame length and completeness.
    task automatic run_frame(input int exp_len);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 60) begin
            tick();
            n++;
        end
        chk("frame_len", frame_len, exp_len);
        chk("done_count", done_cnt, 1);
        chk("bits_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, lane: 0, seq: 8'hA5};
        vecs[1] = '{data: 8'h01, lane: 1, seq: 8'h80};
        vecs[2] = '{data: 8'h3C, lane: 0, seq: 8'h3C};
        vecs[3] = '{data: 8'hC3, lane: 1, seq: 8'hC3};
        vecs[4] = '{data: 8'h0F, lane: 1, seq: 8'hF0};
        vecs[5] = '{data: 8'h96, lane: 1, seq: 8'h69};
        vecs[6] = '{data: 8'hFF, lane: 0, seq: 8'hFF};
        vecs[7] = '{data: 8'h00, lane: 0, seq: 8'h00};

        lane        = 0;
        last_bit    = 1'b1;
        prev_fr     = 1'b0;
        prev_dn     = 1'b0;
        frame_len   = 0;
        done_cnt    = 0;
        dataIn      = '0;
        shiftEn     = 1'b0;
        loadValid_a = 1'b0;
        loadValid_b = 1'b0;

        // Reset asserted between clock edges: outputs must settle without an edge.
        resetN = 1'b1;
        #1;
        resetN = 1'b0;
        #2;
        chk("rst_ser_a", serOut_a, 1);
        chk("rst_frame_a", frame_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_ready_a", loadReady_a, 1);
        chk("rst_ser_b", serOut_b, 1);
        chk("rst_ready_b", loadReady_b, 1);
        repeat (2) tick();
        resetN = 1'b1;
        tick();
        chk("post_rst_ser_a", serOut_a, 1);
        chk("post_rst_frame_a", frame_a, 0);
        chk("post_rst_done_a", done_a, 0);
        chk("post_rst_ready_a", loadReady_a, 1);

        // shiftEn in idle does nothing.
        shiftEn = 1'b1;
        repeat (2) tick();
        shiftEn = 1'b0;
        tick();
        shiftEn = 1'b1;
        tick();

        // Table-driven words on both bit orders.
        for (int v = 0; v < 8; v++) begin
            send_word(vecs[v].data, vecs[v].seq, vecs[v].lane, 1'b0);
            run_frame(8);
            tick();
        end

        // Freeze for three cycles after the 4th bit of A5.
        send_word(8'hA5, 8'hA5, 0, 1'b0);
        repeat (4) tick();
        shiftEn = 1'b0;
        repeat (3) tick();
        chk("frozen_frame", frame_a, 1);
        chk("frozen_ser", serOut_a, 0);
        shiftEn = 1'b1;
        run_frame(11);
        tick();

        // loadValid held high; dataIn changes mid-frame; next word accepted in done cycle.
        send_word(8'h3C, 8'h3C, 0, 1'b1);
        chk("ready_busy", loadReady_a, 0);
        dataIn = 8'h55;
        run_frame(8);
        send_word(8'hC3, 8'hC3, 0, 1'b0);
        chk("ready_busy2", loadReady_a, 0);
        run_frame(8);
        tick();

        // Reset mid-frame aborts without a done pulse; the next word is sent normally.
        send_word(8'hFF, 8'hFF, 0, 1'b0);
        repeat (4) tick();
        chk("pre_abort_frame", frame_a, 1);
        #2;
        resetN = 1'b0;
        #1;
        chk("abort_ser", serOut_a, 1);
        chk("abort_frame", frame_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_ready", loadReady_a, 1);
        exp_q.delete();
        done_cnt = 0;
        repeat (3) tick();
        resetN = 1'b1;
        tick();
        chk("abort_no_done", done_cnt, 0);
        send_word(8'h0F, 8'h0F, 0, 1'b0);
        run_frame(8);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
